// File: rtl/spi_mult_pkg.sv
// -----------------------------------------------------------------------------
// spi_mult_pkg
// Shared definitions for the SPI multiplier front-end (receive) and the MISO
// result stage: receive FSM state encodings, chip-select active level and the
// default operand width / synchroniser depth.
// No ports (package).
// -----------------------------------------------------------------------------
package spi_mult_pkg;

   localparam int   DEF_WIDTH       = 4;
   localparam int   DEF_SYNC_STAGES = 2;

   // Frame is open while the synchronised chip select sits at this level.
   localparam logic CS_ACTIVE       = 1'b1;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_SHIFT = 2'd1,
      RX_HOLD  = 2'd2
   } rx_state_t;

endpackage

// File: rtl/spi_input_sync.sv
// -----------------------------------------------------------------------------
// spi_input_sync
// Brings one asynchronous SPI pin into the clk domain through a STAGES-deep
// flop chain, optionally conditions it, and produces registered rise/fall
// strobes together with a level that is time-aligned with those strobes.
//
// MODE: 0 = plain synchroniser
//       1 = one extra delay flop (keeps a data pin aligned with filtered pins)
//       2 = 2-sample majority filter (level moves only after two equal samples;
//           a single-cycle pulse never reaches the output)
//
// Ports
//   clk    in  system clock
//   reset  in  asynchronous, active-high
//   din    in  raw asynchronous pin
//   level  out conditioned level, aligned with rise/fall
//   rise   out 1-cycle pulse on a conditioned 0->1 transition
//   fall   out 1-cycle pulse on a conditioned 1->0 transition
// -----------------------------------------------------------------------------
module spi_input_sync
   import spi_mult_pkg::*;
#(
   parameter int STAGES = DEF_SYNC_STAGES,
   parameter int MODE   = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              sync;
   logic              clean;
   logic              prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], din};
      end
   end

   assign sync = chain[STAGES-1];

   generate
      if (MODE == 2) begin : g_filt
         logic s_d;
         logic held;
         // Output follows only once two consecutive samples agree, otherwise
         // the previously accepted value is held.
         assign clean = (sync == s_d) ? s_d : held;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               s_d  <= 1'b0;
               held <= 1'b0;
            end else begin
               s_d  <= sync;
               held <= clean;
            end
         end
      end else if (MODE == 1) begin : g_dly
         logic s_d;
         assign clean = s_d;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               s_d <= 1'b0;
            end else begin
               s_d <= sync;
            end
         end
      end else begin : g_none
         assign clean = sync;
      end
   endgenerate

   // Strobes are registered, so level is taken from the same flop stage to
   // keep them in step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         prev <= clean;
         rise <= clean & ~prev;
         fall <= ~clean & prev;
      end
   end

   assign level = prev;

endmodule

// File: rtl/spi_operand_rx.sv
// -----------------------------------------------------------------------------
// spi_operand_rx
// SPI slave receive front-end for the multiplier. Synchronises sclk/cs/mosi,
// deserialises one frame of two WIDTH-bit operands (A then B, MSB first) and
// presents them with a one-cycle valid pulse. sclk edge strobes are exported
// for the MISO result stage.
//
// Build option: define SPI_GLITCH_FILTER_EN to put a 2-sample majority filter
// on sclk and cs after synchronisation (+1 clk strobe latency, 1-clk pulses
// rejected). mosi is delayed by one clk in that build to stay aligned.
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous, active-high
//   sclk_in        in   raw SPI clock (must be slower than clk/4)
//   cs_in          in   raw chip select, active-high
//   mosi_in        in   raw serial data, sampled on sclk rising edge
//   busy           in   downstream multiply in progress; completed frames rejected
//   operand_a      out  first WIDTH bits of the last accepted frame
//   operand_b      out  second WIDTH bits of the last accepted frame
//   operands_valid out  1-cycle pulse, operands newly updated
//   frame_error    out  1-cycle pulse: short frame, overrun or busy reject
//   sclk_rise      out  1-cycle pulse per synchronised sclk rising edge
//   sclk_fall      out  1-cycle pulse per synchronised sclk falling edge
// -----------------------------------------------------------------------------
module spi_operand_rx
   import spi_mult_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sclk_in,
   input  logic             cs_in,
   input  logic             mosi_in,
   input  logic             busy,
   output logic [WIDTH-1:0] operand_a,
   output logic [WIDTH-1:0] operand_b,
   output logic             operands_valid,
   output logic             frame_error,
   output logic             sclk_rise,
   output logic             sclk_fall
);

   localparam int FRAME_BITS = 2 * WIDTH;
   localparam int CNT_W      = $clog2(FRAME_BITS);

`ifdef SPI_GLITCH_FILTER_EN
   localparam int CTRL_MODE = 2;
   localparam int DATA_MODE = 1;
`else
   localparam int CTRL_MODE = 0;
   localparam int DATA_MODE = 0;
`endif

   logic sclk_lvl_unused;
   logic cs_lvl_unused;
   logic cs_rise;
   logic cs_fall;
   logic mosi_lvl;
   logic mosi_rise_unused;
   logic mosi_fall_unused;

   spi_input_sync #(.STAGES(SYNC_STAGES), .MODE(CTRL_MODE)) u_sync_sclk (
      .clk   (clk),
      .reset (reset),
      .din   (sclk_in),
      .level (sclk_lvl_unused),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_input_sync #(.STAGES(SYNC_STAGES), .MODE(CTRL_MODE)) u_sync_cs (
      .clk   (clk),
      .reset (reset),
      .din   (cs_in),
      .level (cs_lvl_unused),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   spi_input_sync #(.STAGES(SYNC_STAGES), .MODE(DATA_MODE)) u_sync_mosi (
      .clk   (clk),
      .reset (reset),
      .din   (mosi_in),
      .level (mosi_lvl),
      .rise  (mosi_rise_unused),
      .fall  (mosi_fall_unused)
   );

   logic                  cs_open;
   logic                  cs_close;
   logic                  last_bit;
   logic [FRAME_BITS-1:0] sr_next;

   rx_state_t             state;
   logic [CNT_W-1:0]      cnt;
   logic [FRAME_BITS-1:0] sr;
   logic                  ovr_seen;

   assign cs_open  = (CS_ACTIVE == 1'b1) ? cs_rise : cs_fall;
   assign cs_close = (CS_ACTIVE == 1'b1) ? cs_fall : cs_rise;
   assign last_bit = (cnt == CNT_W'(FRAME_BITS - 1));
   assign sr_next  = {sr[FRAME_BITS-2:0], mosi_lvl};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= RX_IDLE;
         cnt            <= '0;
         sr             <= '0;
         ovr_seen       <= 1'b0;
         operand_a      <= '0;
         operand_b      <= '0;
         operands_valid <= 1'b0;
         frame_error    <= 1'b0;
      end else begin
         operands_valid <= 1'b0;
         frame_error    <= 1'b0;
         case (state)
            RX_IDLE: begin
               if (cs_open) begin
                  state    <= RX_SHIFT;
                  cnt      <= '0;
                  sr       <= '0;
                  ovr_seen <= 1'b0;
               end
            end
            RX_SHIFT: begin
               // Final bit wins over a coincident cs release: the frame still
               // completes, but since the close strobe is consumed here we go
               // straight back to IDLE instead of waiting in HOLD.
               if (sclk_rise && last_bit) begin
                  sr <= sr_next;
                  if (!busy) begin
                     operand_a      <= sr_next[FRAME_BITS-1:WIDTH];
                     operand_b      <= sr_next[WIDTH-1:0];
                     operands_valid <= 1'b1;
                  end else begin
                     frame_error    <= 1'b1;
                  end
                  state <= cs_close ? RX_IDLE : RX_HOLD;
               end else if (cs_close) begin
                  frame_error <= 1'b1;
                  state       <= RX_IDLE;
               end else if (sclk_rise) begin
                  sr  <= sr_next;
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RX_HOLD: begin
               if (cs_close) begin
                  state <= RX_IDLE;
               end else if (sclk_rise && !ovr_seen) begin
                  frame_error <= 1'b1;
                  ovr_seen    <= 1'b1;
               end
            end
            default: begin
               state <= RX_IDLE;
            end
         endcase
      end
   end

endmodule
